// File: rtl/proc_pkg.sv
// Shared definitions for the 9-bit processor control unit: word width,
// instruction field positions, opcodes and the time-step encoding.
package proc_pkg;

    localparam int N = 9;

    // Instruction format III XXX YYY
    localparam int OP_MSB = 8;
    localparam int OP_LSB = 6;
    localparam int RX_MSB = 5;
    localparam int RX_LSB = 3;
    localparam int RY_MSB = 2;
    localparam int RY_LSB = 0;

    localparam logic [2:0] OP_MV  = 3'b000;
    localparam logic [2:0] OP_MVI = 3'b001;
    localparam logic [2:0] OP_ADD = 3'b010;
    localparam logic [2:0] OP_SUB = 3'b011;

    typedef enum logic [1:0] {
        T0 = 2'd0,
        T1 = 2'd1,
        T2 = 2'd2,
        T3 = 2'd3
    } tstep_e;

endpackage

// File: rtl/dec3to8.sv
// 3-to-8 one-hot decoder with enable; output bit 0 corresponds to select 000.
module dec3to8 (
    input  logic       en,
    input  logic [2:0] sel,
    output logic [0:7] y
);

    // One-hot decode of sel, all zero while disabled
    always_comb begin
        y = 8'b0000_0000;
        if (en) begin
            y[sel] = 1'b1;
        end else begin
            y = 8'b0000_0000;
        end
    end

endmodule

// File: rtl/proc_control_checker.sv
// Structural invariants of the control outputs: a single bus driver and
// zero/one-hot register enables in every cycle.
module proc_control_checker (
    input logic       Clock,
    input logic [0:7] Rin,
    input logic [0:7] Rout,
    input logic       DINout,
    input logic       Gout
);

    a_bus_driver_excl: assert property (@(posedge Clock) $onehot0({|Rout, Gout, DINout}));
    a_rin_onehot0:     assert property (@(posedge Clock) $onehot0(Rin));
    a_rout_onehot0:    assert property (@(posedge Clock) $onehot0(Rout));

endmodule

// File: rtl/proc_control.sv
// Multi-cycle control unit: latches the instruction word and sequences the
// shared-bus register, ALU and bus-driver strobes over time steps T0..T3.
module proc_control #(
    parameter int N = 9
) (
    input  logic         Clock,
    input  logic         Reset,
    input  logic         Run,
    input  logic [N-1:0] DIN,
    output logic         IRin,
    output logic [0:7]   Rin,
    output logic [0:7]   Rout,
    output logic         DINout,
    output logic         Gout,
    output logic         Ain,
    output logic         Gin,
    output logic         AddSub,
    output logic         Done,
    output logic [N-1:0] IR
);

    import proc_pkg::tstep_e;
    import proc_pkg::T0;
    import proc_pkg::T1;
    import proc_pkg::T2;
    import proc_pkg::T3;
    import proc_pkg::OP_MV;
    import proc_pkg::OP_MVI;
    import proc_pkg::OP_ADD;
    import proc_pkg::OP_SUB;
    import proc_pkg::OP_MSB;
    import proc_pkg::OP_LSB;
    import proc_pkg::RX_MSB;
    import proc_pkg::RX_LSB;
    import proc_pkg::RY_MSB;
    import proc_pkg::RY_LSB;

    tstep_e         tstep_r;
    tstep_e         tstep_nxt_s;
    logic [N-1:0]   ir_r;
    logic [2:0]     opcode_s;
    logic           is_arith_s;
    logic           x_en_s;
    logic           y_en_s;
    logic [0:7]     x_dec_s;
    logic [0:7]     y_dec_s;

    assign opcode_s   = ir_r[OP_MSB:OP_LSB];
    assign is_arith_s = (opcode_s == OP_ADD) || (opcode_s == OP_SUB);
    assign IR         = ir_r;

    // Opcodes 000..011 all touch Rx in T1; reserved opcodes have bit 2 set
    assign x_en_s = !Reset && (((tstep_r == T1) && (opcode_s[2] == 1'b0)) ||
                               ((tstep_r == T3) && is_arith_s));
    assign y_en_s = !Reset && (((tstep_r == T1) && (opcode_s == OP_MV)) ||
                               ((tstep_r == T2) && is_arith_s));

    dec3to8 u_dec_x (
        .en  (x_en_s),
        .sel (ir_r[RX_MSB:RX_LSB]),
        .y   (x_dec_s)
    );

    dec3to8 u_dec_y (
        .en  (y_en_s),
        .sel (ir_r[RY_MSB:RY_LSB]),
        .y   (y_dec_s)
    );

    // Time-step register and instruction register
    always_ff @(posedge Clock) begin
        if (Reset) begin
            tstep_r <= T0;
            ir_r    <= '0;
        end else begin
            tstep_r <= tstep_nxt_s;
            if ((tstep_r == T0) && Run) begin
                ir_r <= DIN;
            end else begin
                ir_r <= ir_r;
            end
        end
    end

    // Next-step and strobe decode; Reset forces every strobe low
    always_comb begin
        tstep_nxt_s = tstep_r;
        IRin        = 1'b0;
        Rin         = 8'b0000_0000;
        Rout        = 8'b0000_0000;
        DINout      = 1'b0;
        Gout        = 1'b0;
        Ain         = 1'b0;
        Gin         = 1'b0;
        AddSub      = 1'b0;
        Done        = 1'b0;
        if (Reset) begin
            tstep_nxt_s = T0;
        end else begin
            case (tstep_r)
                T0: begin
                    IRin = Run;
                    if (Run) begin
                        tstep_nxt_s = T1;
                    end else begin
                        tstep_nxt_s = T0;
                    end
                end
                T1: begin
                    tstep_nxt_s = T0;
                    case (opcode_s)
                        OP_MV: begin
                            Rout = y_dec_s;
                            Rin  = x_dec_s;
                            Done = 1'b1;
                        end
                        OP_MVI: begin
                            DINout = 1'b1;
                            Rin    = x_dec_s;
                            Done   = 1'b1;
                        end
                        OP_ADD, OP_SUB: begin
                            Rout        = x_dec_s;
                            Ain         = 1'b1;
                            tstep_nxt_s = T2;
                        end
                        default: begin
                            Done = 1'b1;
                        end
                    endcase
                end
                T2: begin
                    if (is_arith_s) begin
                        Rout        = y_dec_s;
                        Gin         = 1'b1;
                        AddSub      = opcode_s[0];
                        tstep_nxt_s = T3;
                    end else begin
                        tstep_nxt_s = T0;
                    end
                end
                T3: begin
                    tstep_nxt_s = T0;
                    if (is_arith_s) begin
                        Gout = 1'b1;
                        Rin  = x_dec_s;
                        Done = 1'b1;
                    end else begin
                        Done = 1'b0;
                    end
                end
                default: begin
                    tstep_nxt_s = T0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_proc_control.sv
// Bench for proc_control: per-cycle vector table through a scoreboard queue,
// plus a bounded latency sequence for a subtract instruction.
module tb_proc_control;

    logic       Clock;
    logic       Reset;
    logic       Run;
    logic [8:0] DIN;
    logic       IRin;
    logic [0:7] Rin;
    logic [0:7] Rout;
    logic       DINout;
    logic       Gout;
    logic       Ain;
    logic       Gin;
    logic       AddSub;
    logic       Done;
    logic [8:0] IR;

    int n_pass;
    int n_total;

    proc_control #(.N(9)) dut (
        .Clock(Clock), .Reset(Reset), .Run(Run), .DIN(DIN),
        .IRin(IRin), .Rin(Rin), .Rout(Rout), .DINout(DINout), .Gout(Gout),
        .Ain(Ain), .Gin(Gin), .AddSub(AddSub), .Done(Done), .IR(IR)
    );

    proc_control_checker u_chk (
        .Clock(Clock), .Rin(Rin), .Rout(Rout), .DINout(DINout), .Gout(Gout)
    );

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    // strobe field order: DINout Gout Ain Gin AddSub Done
    localparam logic [5:0] S_NONE = 6'b000000;
    localparam logic [5:0] S_MVI  = 6'b100001;
    localparam logic [5:0] S_DONE = 6'b000001;
    localparam logic [5:0] S_AIN  = 6'b001000;
    localparam logic [5:0] S_ADD2 = 6'b000100;
    localparam logic [5:0] S_SUB2 = 6'b000110;
    localparam logic [5:0] S_WB   = 6'b010001;

    typedef struct {
        string      nm;
        logic       rst;
        logic       run;
        logic [8:0] din;
        logic [31:0] exp;
    } vec_t;

    vec_t        tbl[$];
    logic [31:0] exp_q[$];

    function automatic logic [31:0] o(logic irin, logic [7:0] rin, logic [7:0] rout,
                                      logic [5:0] strb, logic [8:0] ir);
        return {irin, rin, rout, strb, ir};
    endfunction

    function automatic void row(string nm, logic rst, logic run, logic [8:0] din,
                                logic [31:0] exp);
        tbl.push_back('{nm, rst, run, din, exp});
    endfunction

    function automatic logic [31:0] observed();
        return {IRin, Rin, Rout, DINout, Gout, Ain, Gin, AddSub, Done, IR};
    endfunction

    task automatic check(string nm, logic [31:0] got, logic [31:0] want);
        n_total++;
        if (got === want) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %h expected %h", nm, got, want);
        end
    endtask

    initial begin
        logic [31:0] e;
        int          cycles;
        bit          seen;
        n_pass  = 0;
        n_total = 0;
        Reset   = 1'b1;
        Run     = 1'b1;
        DIN     = 9'd0;

        // Reset held with Run high: everything zero
        row("rst0",       1'b1, 1'b1, 9'b000_000_000, o(1'b0, 8'b0, 8'b0, S_NONE, 9'b000_000_000));
        row("rst1",       1'b1, 1'b1, 9'b000_000_000, o(1'b0, 8'b0, 8'b0, S_NONE, 9'b000_000_000));
        // mvi R2,#5
        row("mvi_t0",     1'b0, 1'b1, 9'b001_010_000, o(1'b1, 8'b0, 8'b0, S_NONE, 9'b000_000_000));
        row("mvi_t1",     1'b0, 1'b0, 9'b000_000_101, o(1'b0, 8'b00100000, 8'b0, S_MVI, 9'b001_010_000));
        row("idle_t0",    1'b0, 1'b0, 9'b000_000_000, o(1'b0, 8'b0, 8'b0, S_NONE, 9'b001_010_000));
        // mv R7,R0
        row("mv_t0",      1'b0, 1'b1, 9'b000_111_000, o(1'b1, 8'b0, 8'b0, S_NONE, 9'b001_010_000));
        row("mv_t1",      1'b0, 1'b0, 9'b000_000_000, o(1'b0, 8'b00000001, 8'b10000000, S_DONE, 9'b000_111_000));
        // sub R1,R3
        row("sub_t0",     1'b0, 1'b1, 9'b011_001_011, o(1'b1, 8'b0, 8'b0, S_NONE, 9'b000_111_000));
        row("sub_t1",     1'b0, 1'b0, 9'b000_000_000, o(1'b0, 8'b0, 8'b01000000, S_AIN, 9'b011_001_011));
        row("sub_t2",     1'b0, 1'b0, 9'b000_000_000, o(1'b0, 8'b0, 8'b00010000, S_SUB2, 9'b011_001_011));
        row("sub_t3",     1'b0, 1'b0, 9'b000_000_000, o(1'b0, 8'b01000000, 8'b0, S_WB, 9'b011_001_011));
        row("sub_idle",   1'b0, 1'b0, 9'b000_000_000, o(1'b0, 8'b0, 8'b0, S_NONE, 9'b011_001_011));
        // add R4,R6 aborted by reset in T2
        row("add_t0",     1'b0, 1'b1, 9'b010_100_110, o(1'b1, 8'b0, 8'b0, S_NONE, 9'b011_001_011));
        row("add_t1",     1'b0, 1'b0, 9'b000_000_000, o(1'b0, 8'b0, 8'b00001000, S_AIN, 9'b010_100_110));
        row("add_rst_t2", 1'b1, 1'b1, 9'b000_000_000, o(1'b0, 8'b0, 8'b0, S_NONE, 9'b010_100_110));
        row("post_rst",   1'b0, 1'b0, 9'b000_000_000, o(1'b0, 8'b0, 8'b0, S_NONE, 9'b000_000_000));
        // mv R3,R3 with Run held; DIN in T1 must be ignored
        row("mvs_t0",     1'b0, 1'b1, 9'b000_011_011, o(1'b1, 8'b0, 8'b0, S_NONE, 9'b000_000_000));
        row("mvs_t1",     1'b0, 1'b1, 9'b010_000_001, o(1'b0, 8'b00010000, 8'b00010000, S_DONE, 9'b000_011_011));
        // add R0,R1 back-to-back, then reserved opcode 101
        row("b2b_add_t0", 1'b0, 1'b1, 9'b010_000_001, o(1'b1, 8'b0, 8'b0, S_NONE, 9'b000_011_011));
        row("b2b_add_t1", 1'b0, 1'b1, 9'b101_111_111, o(1'b0, 8'b0, 8'b10000000, S_AIN, 9'b010_000_001));
        row("b2b_add_t2", 1'b0, 1'b1, 9'b101_111_111, o(1'b0, 8'b0, 8'b01000000, S_ADD2, 9'b010_000_001));
        row("b2b_add_t3", 1'b0, 1'b1, 9'b101_111_111, o(1'b0, 8'b10000000, 8'b0, S_WB, 9'b010_000_001));
        row("b2b_nop_t0", 1'b0, 1'b1, 9'b101_111_111, o(1'b1, 8'b0, 8'b0, S_NONE, 9'b010_000_001));
        row("nop_t1",     1'b0, 1'b0, 9'b000_000_000, o(1'b0, 8'b0, 8'b0, S_DONE, 9'b101_111_111));
        row("nop_idle",   1'b0, 1'b0, 9'b000_000_000, o(1'b0, 8'b0, 8'b0, S_NONE, 9'b101_111_111));

        // One reset edge so IR is defined before the table starts
        @(posedge Clock);

        foreach (tbl[i]) begin
            @(negedge Clock);
            Reset = tbl[i].rst;
            Run   = tbl[i].run;
            DIN   = tbl[i].din;
            exp_q.push_back(tbl[i].exp);
            #2;
            e = exp_q.pop_front();
            check(tbl[i].nm, observed(), e);
        end

        // sub R7,R6: Done must arrive exactly 3 cycles after the fetch cycle
        @(negedge Clock);
        Reset = 1'b0;
        Run   = 1'b1;
        DIN   = 9'b011_111_110;
        #2;
        check("lat_fetch_irin", {31'd0, IRin}, 32'd1);
        cycles = 0;
        seen   = 1'b0;
        for (int k = 1; k <= 8 && !seen; k++) begin
            @(negedge Clock);
            Run = 1'b0;
            DIN = 9'd0;
            #2;
            if (Done) begin
                seen   = 1'b1;
                cycles = k;
                check("lat_done_rin", {24'd0, Rin}, 32'h0000_0001);
                check("lat_done_gout", {31'd0, Gout}, 32'd1);
            end
        end
        check("lat_cycles", cycles, 32'd3);
        check("lat_ir", {23'd0, IR}, {23'd0, 9'b011_111_110});

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/proc_control.md
# proc_control

Multi-cycle control unit for the 9-bit processor datapath. It latches each instruction word from `DIN` and steps through up to four time steps (T0–T3). In each step it produces the one-hot register enables (`Rin`, `Rout`) and the bus/ALU strobes that the shared-bus datapath consumes. Register-field one-hot decoding is delegated to two 3-to-8 decoder instances that sit directly downstream of this block's field/enable logic.

## Interface
Parameters:
- `N`, 9: instruction/data word width. Instruction format is fixed at III XXX YYY (bits 8:6 opcode, 5:3 Rx, 2:0 Ry), so `N` must be 9.

Ports:
- `Clock`, in, 1: single clock; all state changes on the rising edge.
- `Reset`, in, 1: synchronous, active-high reset.
- `Run`, in, 1: start request; sampled only in T0.
- `DIN`, in, N: instruction word (in T0) and immediate operand (in mvi T1).
- `IRin`, out, 1: instruction-register load strobe (informational; the IR is internal).
- `Rin`, out, [0:7]: one-hot register write enable; bit 0 = R0.
- `Rout`, out, [0:7]: one-hot register bus-drive enable; bit 0 = R0.
- `DINout`, out, 1: `DIN` drives the bus.
- `Gout`, out, 1: G register drives the bus.
- `Ain`, out, 1: load A from the bus.
- `Gin`, out, 1: load G with the ALU result.
- `AddSub`, out, 1: 0 = add, 1 = subtract; meaningful only while `Gin` = 1.
- `Done`, out, 1: final step of the instruction.
- `IR`, out, N: current instruction register contents, for debug/observation.

## Operation
- State register `Tstep` ∈ {T0, T1, T2, T3}. Instruction register `IR` is N bits wide.
- T0: `IRin` = `Run`.
  - If `Run` = 1: `IR` ← `DIN` at the edge, then go to T1.
  - Otherwise stay in T0 and `IR` holds.
- Opcode 000, mv Rx,Ry:
  - T1: `Rout` = onehot(Ry), `Rin` = onehot(Rx), `Done` = 1, then go to T0.
- Opcode 001, mvi Rx,#D:
  - T1: `DINout` = 1, `Rin` = onehot(Rx), `Done` = 1, then go to T0.
- Opcode 010 add / 011 sub:
  - T1: `Rout` = onehot(Rx), `Ain` = 1, then go to T2.
  - T2: `Rout` = onehot(Ry), `Gin` = 1, `AddSub` = opcode[0], then go to T3.
  - T3: `Gout` = 1, `Rin` = onehot(Rx), `Done` = 1, then go to T0.
- Opcodes 100–111 (reserved): T1 asserts `Done` only, with no bus driver and no `Rin`, then go to T0. This is a NOP.
- Output rules:
  - All outputs except `IR` are combinational from `Tstep` and `IR`.
  - Every strobe not listed for the current step is 0.
  - At most one of {any `Rout` bit, `Gout`, `DINout`} is 1 in any cycle.
  - `Rin` and `Rout` are each zero-hot or one-hot.
- mv with Rx = Ry is legal: the same bit is set in both `Rin` and `Rout`.
- `Run` is ignored outside T0. Deasserting `Run` mid-instruction does not abort the instruction.

## Timing
- Reset edge: `Tstep` ← T0 and `IR` ← 0.
  - While `Reset` = 1, every output is 0, including `IRin` regardless of `Run`.
- Reset asserted mid-instruction aborts it. The cycle after reset is T0, and no `Done` is issued for the aborted instruction.
- Latency from the T0 cycle with `Run` = 1 to the `Done` cycle:
  - mv, mvi, NOP: 1 cycle (2 cycles total).
  - add, sub: 3 cycles (4 cycles total).
- Back-to-back execution: with `Run` held at 1, the cycle after `Done` is T0 with `IRin` = 1, so the next instruction is fetched with no idle gap.
- `IR` changes only at a T0 edge with `Run` = 1. It is stable throughout T1–T3.

## Structure
- Shared package `proc_pkg` holds:
  - opcode constants `OP_MV`, `OP_MVI`, `OP_ADD`, `OP_SUB`;
  - the `Tstep` state enum (T0–T3);
  - the IR field bit positions;
  - `N`.
- Sub-module: two instances of the team's existing 3-to-8 one-hot decoder (`dec3to8`, enable plus 3-bit select, [0:7] output, bit 0 for select 000).
  - One instance decodes `IR`[5:3] (X) and one decodes `IR`[2:0] (Y).
  - Their enables are driven high whenever the current step uses that field.
  - The block selects which decoded vector feeds `Rin` or `Rout` per step.
- The step register and `IR` sit in a single clocked process. Output decode sits in a single combinational process.

## Test plan
- Reset held 2 cycles with `Run` = 1 → all outputs 0 and `IR` = 0. After release, T0 with `IRin` = 1.
- mvi R2,#5: T0 `DIN` = 9'b001_010_000, T1 `DIN` = 5 → T1 has `DINout` = 1, `Rin` = 8'b00100000, `Done` = 1. Next cycle is T0.
- mv R7,R0: `DIN` = 9'b000_111_000 → T1 has `Rout` = 8'b10000000, `Rin` = 8'b00000001, `Done` = 1.
- sub R1,R3: `DIN` = 9'b011_001_011 → check each step:
  - T1: `Rout` = 8'b01000000, `Ain` = 1.
  - T2: `Rout` = 8'b00010000, `Gin` = 1, `AddSub` = 1.
  - T3: `Gout` = 1, `Rin` = 8'b01000000, `Done` = 1.
- add instruction fetched, then `Reset` asserted in T2 → next cycle T0 with all outputs 0 and no `Done`. A subsequent mv executes correctly.
- `Run` held high over add followed by reserved opcode 101 → `IRin` = 1 in the cycle after add's `Done`. The NOP asserts only `Done` in T1, and the bus-driver exclusivity assertion holds every cycle.
